// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared MIPS CPU opcodes and store-unit state type
package mips_cpu_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LWL = 6'b100010;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWR = 6'b100110;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SWL = 6'b101010;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SWR = 6'b101110;

  typedef enum logic [1:0] {IDLE, WRITE, RESP} store_state_t;

endpackage

// File: rtl/mips_cpu_store_align.sv
// rtl/mips_cpu_store_align.sv - store lane formatting: byte enables and lane-aligned data
module mips_cpu_store_align
  import mips_cpu_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  off,
  input  logic [31:0] rt,
  output logic [3:0]  be,
  output logic [31:0] data,
  output logic        misaligned,
  output logic        illegal
);

  always_comb begin
    be         = 4'b0000;
    data       = 32'h0;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (opcode)
      OP_SB: begin
        be   = 4'b0001 << off;
        data = {4{rt[7:0]}};
      end
      OP_SH: begin
        misaligned = off[0];
        be         = off[1] ? 4'b1100 : 4'b0011;
        data       = {2{rt[15:0]}};
      end
      OP_SW: begin
        misaligned = (off != 2'b00);
        be         = 4'b1111;
        data       = rt;
      end
      // swl writes the high end of rt into the low lanes up to the addressed byte
      OP_SWL: begin
        case (off)
          2'b00:   begin be = 4'b0001; data = {24'h0, rt[31:24]}; end
          2'b01:   begin be = 4'b0011; data = {16'h0, rt[31:16]}; end
          2'b10:   begin be = 4'b0111; data = {8'h0, rt[31:8]};   end
          default: begin be = 4'b1111; data = rt;                 end
        endcase
      end
      OP_SWR: begin
        case (off)
          2'b00:   begin be = 4'b1111; data = rt;                 end
          2'b01:   begin be = 4'b1110; data = {rt[23:0], 8'h0};   end
          2'b10:   begin be = 4'b1100; data = {rt[15:0], 16'h0};  end
          default: begin be = 4'b1000; data = {rt[7:0], 24'h0};   end
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_cpu_store_unit.sv
// rtl/mips_cpu_store_unit.sv - store unit: one byte-enabled data-memory write per request
module mips_cpu_store_unit
  import mips_cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] rtdata,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [3:0]  mem_byteenable,
  output logic [31:0] mem_writedata,
  input  logic        mem_waitrequest,
  output logic        done,
  output logic        err
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  store_state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          fail_q, fail_d;
  logic          accept;
  logic [31:2]   addr_q;
  logic [3:0]    be_q;
  logic [31:0]   data_q;

  logic [3:0]    al_be;
  logic [31:0]   al_data;
  logic          al_misaligned;
  logic          al_illegal;

  mips_cpu_store_align u_align (
    .opcode     (opcode),
    .off        (addr[1:0]),
    .rt         (rtdata),
    .be         (al_be),
    .data       (al_data),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      fail_q <= 1'b0;
      addr_q <= '0;
      be_q   <= 4'b0000;
      data_q <= 32'h0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      fail_q <= fail_d;
      if (accept) begin
        addr_q <= addr[31:2];
        be_q   <= al_be;
        data_q <= al_data;
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    fail_d  = fail_q;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          accept = 1'b1;
          if (al_misaligned || al_illegal) begin
            state_d = RESP;
            fail_d  = 1'b1;
          end else begin
            state_d = WRITE;
            fail_d  = 1'b0;
          end
        end
      end
      WRITE: begin
        if (!mem_waitrequest) begin
          state_d = RESP;
          fail_d  = 1'b0;
        end else begin
          cnt_d = cnt + CW'(1);
          if (TIMEOUT_CYCLES > 0 && cnt_d == TMAX) begin
            state_d = RESP;
            fail_d  = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs decode straight from state so a reset drops the strobe at once
  assign req_ready      = (state == IDLE);
  assign mem_write      = (state == WRITE);
  assign mem_byteenable = (state == WRITE) ? be_q : 4'b0000;
  assign mem_address    = {addr_q, 2'b00};
  assign mem_writedata  = data_q;
  assign done           = (state == RESP) && !fail_q;
  assign err            = (state == RESP) && fail_q;

endmodule
